// File: rtl/lotr_pkg.sv
// Shared ring types: opcode encoding, the ring slot layout and the bit
// ranges that carry the destination tile id inside a slot.
package lotr_pkg;

  typedef enum logic [3:0] {
    OP_READ   = 4'h0,
    OP_WRITE  = 4'h1,
    OP_ATOMIC = 4'h2,
    OP_FLUSH  = 4'h3
  } t_opcode;

  // Destination tile of a request lives in the top byte of the address.
  localparam int CORE_ID_MSB = 31;
  localparam int CORE_ID_LSB = 24;

  // Destination tile of a response lives in requestor[9:2].
  localparam int RSP_ID_MSB = 9;
  localparam int RSP_ID_LSB = 2;

  typedef struct packed {
    logic        valid;
    logic [9:0]  requestor;
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_slot;

  // Saturating 16-bit increment used by the optional event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic evt);
    if (evt && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

endpackage

// File: rtl/ring_stop_fifo.sv
// Local request injection FIFO. Power-of-two depth, pointers wrap
// naturally. A push is ignored when full and a pop when empty, so the
// caller may drive push/pop from its own qualifiers without extra guards.
module ring_stop_fifo
  import lotr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  t_slot push_data_i,
  input  logic  pop_i,
  output t_slot head_o,
  output logic  empty_o,
  output logic  full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  t_slot              mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless once the count is cleared.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ring_stop.sv
// Ring stop: one tile's tap on a request ring and a response ring.
// Each ring slot is registered at Q501 and re-registered at Q502 (fixed
// 2-cycle hop). At Q501 a slot addressed to this tile may be ejected;
// a free slot (invalid or just ejected) may be refilled from the local
// request FIFO (request ring) or the one-entry response holder.
// Optional: define RING_STOP_PERF_CNT_EN to add four saturating event
// counters (PerfReqFwd/PerfReqInj/PerfReqEj/PerfReqBounce).
//
// Handshakes: on LocalReqIn/LocalRspIn a transfer happens on a clock
// edge where Valid && Ready. LocalReqOut offers a locally addressed slot
// for exactly one cycle; it is taken only if LocalReqOutReady is high in
// that cycle, otherwise the slot stays on the ring and comes round again.
// LocalRspOut has no ready: every local response pulses for one cycle.
module ring_stop
  import lotr_pkg::*;
#(
  parameter int INJ_FIFO_DEPTH = 4
) (
  input  logic        QClk,
  input  logic        RstQnnnL,
  input  logic [7:0]  CoreID,
`ifdef RING_STOP_PERF_CNT_EN
  output logic [15:0] PerfReqFwd,
  output logic [15:0] PerfReqInj,
  output logic [15:0] PerfReqEj,
  output logic [15:0] PerfReqBounce,
`endif
  input  logic        RingReqInValidQ500H,
  input  logic [9:0]  RingReqInRequestorQ500H,
  input  t_opcode     RingReqInOpcodeQ500H,
  input  logic [31:0] RingReqInAddressQ500H,
  input  logic [31:0] RingReqInDataQ500H,
  input  logic        RingRspInValidQ500H,
  input  logic [9:0]  RingRspInRequestorQ500H,
  input  t_opcode     RingRspInOpcodeQ500H,
  input  logic [31:0] RingRspInAddressQ500H,
  input  logic [31:0] RingRspInDataQ500H,
  output logic        RingReqOutValidQ502H,
  output logic [9:0]  RingReqOutRequestorQ502H,
  output t_opcode     RingReqOutOpcodeQ502H,
  output logic [31:0] RingReqOutAddressQ502H,
  output logic [31:0] RingReqOutDataQ502H,
  output logic        RingRspOutValidQ502H,
  output logic [9:0]  RingRspOutRequestorQ502H,
  output t_opcode     RingRspOutOpcodeQ502H,
  output logic [31:0] RingRspOutAddressQ502H,
  output logic [31:0] RingRspOutDataQ502H,
  input  logic        LocalReqInValid,
  input  logic [9:0]  LocalReqInRequestor,
  input  t_opcode     LocalReqInOpcode,
  input  logic [31:0] LocalReqInAddress,
  input  logic [31:0] LocalReqInData,
  output logic        LocalReqInReady,
  input  logic        LocalRspInValid,
  input  logic [9:0]  LocalRspInRequestor,
  input  t_opcode     LocalRspInOpcode,
  input  logic [31:0] LocalRspInAddress,
  input  logic [31:0] LocalRspInData,
  output logic        LocalRspInReady,
  output logic        LocalReqOutValid,
  output logic [9:0]  LocalReqOutRequestor,
  output t_opcode     LocalReqOutOpcode,
  output logic [31:0] LocalReqOutAddress,
  output logic [31:0] LocalReqOutData,
  input  logic        LocalReqOutReady,
  output logic        LocalRspOutValid,
  output logic [9:0]  LocalRspOutRequestor,
  output t_opcode     LocalRspOutOpcode,
  output logic [31:0] LocalRspOutAddress,
  output logic [31:0] LocalRspOutData
);

  t_slot ring_req_in, ring_rsp_in, loc_req_in, loc_rsp_in;
  t_slot req_q501_q, rsp_q501_q;
  t_slot req_q502_q, req_q502_d, rsp_q502_q, rsp_q502_d;
  t_slot rsp_hold_q, rsp_hold_d;
  t_slot fifo_head;
  logic  fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic  ready_en_q;
  logic  req_local, req_eject, req_bounce, req_slot_free, req_inject;
  logic  rsp_local, rsp_slot_free, rsp_inject, rsp_push;

  assign ring_req_in = '{valid: RingReqInValidQ500H, requestor: RingReqInRequestorQ500H,
                         opcode: RingReqInOpcodeQ500H, address: RingReqInAddressQ500H,
                         data: RingReqInDataQ500H};
  assign ring_rsp_in = '{valid: RingRspInValidQ500H, requestor: RingRspInRequestorQ500H,
                         opcode: RingRspInOpcodeQ500H, address: RingRspInAddressQ500H,
                         data: RingRspInDataQ500H};
  assign loc_req_in  = '{valid: 1'b1, requestor: LocalReqInRequestor,
                         opcode: LocalReqInOpcode, address: LocalReqInAddress,
                         data: LocalReqInData};
  assign loc_rsp_in  = '{valid: 1'b1, requestor: LocalRspInRequestor,
                         opcode: LocalRspInOpcode, address: LocalRspInAddress,
                         data: LocalRspInData};

  // Q501 capture of both incoming ring slots.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      req_q501_q <= '0;
      rsp_q501_q <= '0;
    end else begin
      req_q501_q <= ring_req_in;
      rsp_q501_q <= ring_rsp_in;
    end
  end

  // Ejection decisions and slot-free qualifiers, all gated by Valid.
  always_comb begin
    req_local     = req_q501_q.valid && (req_q501_q.address[CORE_ID_MSB:CORE_ID_LSB] == CoreID);
    req_eject     = req_local && LocalReqOutReady;
    req_bounce    = req_local && !LocalReqOutReady;
    req_slot_free = !req_q501_q.valid || req_eject;
    req_inject    = req_slot_free && !fifo_empty;
    rsp_local     = rsp_q501_q.valid && (rsp_q501_q.requestor[RSP_ID_MSB:RSP_ID_LSB] == CoreID);
    rsp_slot_free = !rsp_q501_q.valid || rsp_local;
    rsp_inject    = rsp_slot_free && rsp_hold_q.valid;
  end

  // Ready is held low in reset and for the first edge after it.
  assign LocalReqInReady = ready_en_q && !fifo_full;
  assign LocalRspInReady = ready_en_q && (!rsp_hold_q.valid || rsp_inject);
  assign fifo_push       = LocalReqInValid && LocalReqInReady;
  assign fifo_pop        = req_inject;
  assign rsp_push        = LocalRspInValid && LocalRspInReady;

  ring_stop_fifo #(
    .DEPTH (INJ_FIFO_DEPTH)
  ) u_inj_fifo (
    .clk_i       (QClk),
    .rst_ni      (RstQnnnL),
    .push_i      (fifo_push),
    .push_data_i (loc_req_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Q502 next value: occupied slot wins, else injection, else an empty
  // slot that keeps its stale payload.
  always_comb begin
    req_q502_d       = req_q502_q;
    req_q502_d.valid = 1'b0;
    if (!req_slot_free) begin
      req_q502_d = req_q501_q;
    end else if (req_inject) begin
      req_q502_d       = fifo_head;
      req_q502_d.valid = 1'b1;
    end
    rsp_q502_d       = rsp_q502_q;
    rsp_q502_d.valid = 1'b0;
    if (!rsp_slot_free) begin
      rsp_q502_d = rsp_q501_q;
    end else if (rsp_inject) begin
      rsp_q502_d       = rsp_hold_q;
      rsp_q502_d.valid = 1'b1;
    end
  end

  // Response holder: drained by injection, refilled by an accepted push.
  always_comb begin
    rsp_hold_d = rsp_hold_q;
    if (rsp_inject) rsp_hold_d.valid = 1'b0;
    if (rsp_push)   rsp_hold_d = loc_rsp_in;
  end

  // Q502 output flops, response holder and ready enable.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      req_q502_q <= '0;
      rsp_q502_q <= '0;
      rsp_hold_q <= '0;
      ready_en_q <= 1'b0;
    end else begin
      req_q502_q <= req_q502_d;
      rsp_q502_q <= rsp_q502_d;
      rsp_hold_q <= rsp_hold_d;
      ready_en_q <= 1'b1;
    end
  end

  assign RingReqOutValidQ502H     = req_q502_q.valid;
  assign RingReqOutRequestorQ502H = req_q502_q.requestor;
  assign RingReqOutOpcodeQ502H    = req_q502_q.opcode;
  assign RingReqOutAddressQ502H   = req_q502_q.address;
  assign RingReqOutDataQ502H      = req_q502_q.data;
  assign RingRspOutValidQ502H     = rsp_q502_q.valid;
  assign RingRspOutRequestorQ502H = rsp_q502_q.requestor;
  assign RingRspOutOpcodeQ502H    = rsp_q502_q.opcode;
  assign RingRspOutAddressQ502H   = rsp_q502_q.address;
  assign RingRspOutDataQ502H      = rsp_q502_q.data;

  assign LocalReqOutValid     = req_local;
  assign LocalReqOutRequestor = req_q501_q.requestor;
  assign LocalReqOutOpcode    = req_q501_q.opcode;
  assign LocalReqOutAddress   = req_q501_q.address;
  assign LocalReqOutData      = req_q501_q.data;
  assign LocalRspOutValid     = rsp_local;
  assign LocalRspOutRequestor = rsp_q501_q.requestor;
  assign LocalRspOutOpcode    = rsp_q501_q.opcode;
  assign LocalRspOutAddress   = rsp_q501_q.address;
  assign LocalRspOutData      = rsp_q501_q.data;

`ifdef RING_STOP_PERF_CNT_EN
  logic [15:0] perf_fwd_q, perf_inj_q, perf_ej_q, perf_bounce_q;

  // Saturating request-ring event counters.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      perf_fwd_q    <= '0;
      perf_inj_q    <= '0;
      perf_ej_q     <= '0;
      perf_bounce_q <= '0;
    end else begin
      perf_fwd_q    <= sat_inc16(perf_fwd_q, req_q501_q.valid && !req_eject);
      perf_inj_q    <= sat_inc16(perf_inj_q, req_inject);
      perf_ej_q     <= sat_inc16(perf_ej_q, req_eject);
      perf_bounce_q <= sat_inc16(perf_bounce_q, req_bounce);
    end
  end

  assign PerfReqFwd    = perf_fwd_q;
  assign PerfReqInj    = perf_inj_q;
  assign PerfReqEj     = perf_ej_q;
  assign PerfReqBounce = perf_bounce_q;
`endif

endmodule

// File: tb/tb_ring_stop.sv
// Bench for ring_stop: directed scenarios plus a randomized run against
// a slot-level reference model of the ring stop rules.
module tb_ring_stop;
  import lotr_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n;
  logic [7:0] core_id;

  t_slot rreq_in, rrsp_in, lreq_in, lrsp_in;
  logic  lreq_out_ready;

  logic rreq_out_valid, rrsp_out_valid, lreq_out_valid, lrsp_out_valid;
  logic [9:0] rreq_out_requestor, rrsp_out_requestor, lreq_out_requestor, lrsp_out_requestor;
  t_opcode rreq_out_opcode, rrsp_out_opcode, lreq_out_opcode, lrsp_out_opcode;
  logic [31:0] rreq_out_address, rrsp_out_address, lreq_out_address, lrsp_out_address;
  logic [31:0] rreq_out_data, rrsp_out_data, lreq_out_data, lrsp_out_data;
  logic lreq_in_ready, lrsp_in_ready;
`ifdef RING_STOP_PERF_CNT_EN
  logic [15:0] perf_fwd, perf_inj, perf_ej, perf_bounce;
`endif

  int errors = 0;
  int checks = 0;
  logic [$bits(t_slot)-1:0] exp_q[$];

  ring_stop #(.INJ_FIFO_DEPTH(DEPTH)) dut (
    .QClk(clk), .RstQnnnL(rst_n), .CoreID(core_id),
`ifdef RING_STOP_PERF_CNT_EN
    .PerfReqFwd(perf_fwd), .PerfReqInj(perf_inj), .PerfReqEj(perf_ej), .PerfReqBounce(perf_bounce),
`endif
    .RingReqInValidQ500H(rreq_in.valid), .RingReqInRequestorQ500H(rreq_in.requestor),
    .RingReqInOpcodeQ500H(rreq_in.opcode), .RingReqInAddressQ500H(rreq_in.address),
    .RingReqInDataQ500H(rreq_in.data),
    .RingRspInValidQ500H(rrsp_in.valid), .RingRspInRequestorQ500H(rrsp_in.requestor),
    .RingRspInOpcodeQ500H(rrsp_in.opcode), .RingRspInAddressQ500H(rrsp_in.address),
    .RingRspInDataQ500H(rrsp_in.data),
    .RingReqOutValidQ502H(rreq_out_valid), .RingReqOutRequestorQ502H(rreq_out_requestor),
    .RingReqOutOpcodeQ502H(rreq_out_opcode), .RingReqOutAddressQ502H(rreq_out_address),
    .RingReqOutDataQ502H(rreq_out_data),
    .RingRspOutValidQ502H(rrsp_out_valid), .RingRspOutRequestorQ502H(rrsp_out_requestor),
    .RingRspOutOpcodeQ502H(rrsp_out_opcode), .RingRspOutAddressQ502H(rrsp_out_address),
    .RingRspOutDataQ502H(rrsp_out_data),
    .LocalReqInValid(lreq_in.valid), .LocalReqInRequestor(lreq_in.requestor),
    .LocalReqInOpcode(lreq_in.opcode), .LocalReqInAddress(lreq_in.address),
    .LocalReqInData(lreq_in.data), .LocalReqInReady(lreq_in_ready),
    .LocalRspInValid(lrsp_in.valid), .LocalRspInRequestor(lrsp_in.requestor),
    .LocalRspInOpcode(lrsp_in.opcode), .LocalRspInAddress(lrsp_in.address),
    .LocalRspInData(lrsp_in.data), .LocalRspInReady(lrsp_in_ready),
    .LocalReqOutValid(lreq_out_valid), .LocalReqOutRequestor(lreq_out_requestor),
    .LocalReqOutOpcode(lreq_out_opcode), .LocalReqOutAddress(lreq_out_address),
    .LocalReqOutData(lreq_out_data), .LocalReqOutReady(lreq_out_ready),
    .LocalRspOutValid(lrsp_out_valid), .LocalRspOutRequestor(lrsp_out_requestor),
    .LocalRspOutOpcode(lrsp_out_opcode), .LocalRspOutAddress(lrsp_out_address),
    .LocalRspOutData(lrsp_out_data)
  );

  function automatic t_slot ring_req_out();
    return {rreq_out_valid, rreq_out_requestor, rreq_out_opcode, rreq_out_address, rreq_out_data};
  endfunction
  function automatic t_slot ring_rsp_out();
    return {rrsp_out_valid, rrsp_out_requestor, rrsp_out_opcode, rrsp_out_address, rrsp_out_data};
  endfunction
  function automatic t_slot loc_req_out();
    return {lreq_out_valid, lreq_out_requestor, lreq_out_opcode, lreq_out_address, lreq_out_data};
  endfunction
  function automatic t_slot loc_rsp_out();
    return {lrsp_out_valid, lrsp_out_requestor, lrsp_out_opcode, lrsp_out_address, lrsp_out_data};
  endfunction

  // Random valid slot whose request destination byte is dest.
  function automatic t_slot rnd_slot(input logic [7:0] dest);
    t_slot s;
    s.valid     = 1'b1;
    s.requestor = 10'($urandom_range(0, 1023));
    s.opcode    = t_opcode'($urandom_range(0, 3));
    s.address   = {dest, 24'($urandom())};
    s.data      = $urandom();
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rreq_in = '0; rrsp_in = '0; lreq_in = '0; lrsp_in = '0;
    lreq_out_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    core_id = 8'h02;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) tick();
    checks++; if ({rreq_out_valid, rrsp_out_valid, lreq_out_valid, lrsp_out_valid} !== 4'b0)
      begin errors++; $display("FAIL reset_valids: got %b want 0000", {rreq_out_valid, rrsp_out_valid, lreq_out_valid, lrsp_out_valid}); end
    checks++; if ({lreq_in_ready, lrsp_in_ready} !== 2'b00)
      begin errors++; $display("FAIL reset_ready_low: got %b want 00", {lreq_in_ready, lrsp_in_ready}); end
    rst_n = 1'b1;
    #1;
    checks++; if ({lreq_in_ready, lrsp_in_ready} !== 2'b00)
      begin errors++; $display("FAIL ready_before_first_clk: got %b want 00", {lreq_in_ready, lrsp_in_ready}); end
    tick();
    checks++; if ({lreq_in_ready, lrsp_in_ready} !== 2'b11)
      begin errors++; $display("FAIL ready_after_first_clk: got %b want 11", {lreq_in_ready, lrsp_in_ready}); end
  endtask

  task automatic test_forward();
    t_slot s;
    core_id = 8'h02;
    do_reset();
    s = rnd_slot(8'h03);
    s.address = 32'h0300_0010;
    rreq_in = s;
    tick();
    rreq_in = '0;
    checks++; if (rreq_out_valid !== 1'b0)
      begin errors++; $display("FAIL fwd_early: got %b want 0", rreq_out_valid); end
    checks++; if (lreq_out_valid !== 1'b0)
      begin errors++; $display("FAIL fwd_no_eject: got %b want 0", lreq_out_valid); end
    tick();
    checks++; if (ring_req_out() !== s)
      begin errors++; $display("FAIL fwd_slot: got %h want %h", ring_req_out(), s); end
    tick();
    checks++; if (rreq_out_valid !== 1'b0)
      begin errors++; $display("FAIL fwd_after: got %b want 0", rreq_out_valid); end
  endtask

  task automatic test_eject();
    t_slot s;
    core_id = 8'h02;
    do_reset();
    s = rnd_slot(8'h02);
    s.address = 32'h0200_0040;
    lreq_out_ready = 1'b1;
    rreq_in = s;
    tick();
    rreq_in = '0;
    #1;
    checks++; if (loc_req_out() !== s)
      begin errors++; $display("FAIL eject_local_out: got %h want %h", loc_req_out(), s); end
    tick();
    checks++; if (rreq_out_valid !== 1'b0)
      begin errors++; $display("FAIL eject_ring_slot: got %b want 0", rreq_out_valid); end
    checks++; if (lreq_out_valid !== 1'b0)
      begin errors++; $display("FAIL eject_one_cycle: got %b want 0", lreq_out_valid); end
`ifdef RING_STOP_PERF_CNT_EN
    checks++; if ({perf_ej, perf_fwd, perf_bounce} !== {16'd1, 16'd0, 16'd0})
      begin errors++; $display("FAIL eject_perf: got ej=%0d fwd=%0d bnc=%0d want 1 0 0", perf_ej, perf_fwd, perf_bounce); end
`endif
  endtask

  task automatic test_bounce();
    t_slot s;
    core_id = 8'h02;
    do_reset();
    s = rnd_slot(8'h02);
    s.address = 32'h0200_0040;
    lreq_out_ready = 1'b0;
    rreq_in = s;
    tick();
    rreq_in = '0;
    #1;
    checks++; if (lreq_out_valid !== 1'b1)
      begin errors++; $display("FAIL bounce_offer: got %b want 1", lreq_out_valid); end
    tick();
    checks++; if (ring_req_out() !== s)
      begin errors++; $display("FAIL bounce_forward: got %h want %h", ring_req_out(), s); end
`ifdef RING_STOP_PERF_CNT_EN
    checks++; if ({perf_bounce, perf_fwd, perf_ej} !== {16'd1, 16'd1, 16'd0})
      begin errors++; $display("FAIL bounce_perf: got bnc=%0d fwd=%0d ej=%0d want 1 1 0", perf_bounce, perf_fwd, perf_ej); end
`endif
    lreq_out_ready = 1'b1;
  endtask

  task automatic test_backpressure();
    t_slot got;
    core_id = 8'h02;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      rreq_in = rnd_slot(8'h05);
      lreq_in = rnd_slot(8'h07);
      #1;
      checks++; if (lreq_in_ready !== (i < DEPTH))
        begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", i, lreq_in_ready, (i < DEPTH)); end
      if (i < DEPTH) exp_q.push_back(lreq_in);
      if (i >= 2) begin
        checks++; if (!(rreq_out_valid === 1'b1 && rreq_out_address[31:24] === 8'h05))
          begin errors++; $display("FAIL bp_ring_busy[%0d]: got v=%b addr=%h want ring traffic", i, rreq_out_valid, rreq_out_address); end
      end
      tick();
    end
    lreq_in = '0;
    for (int j = 0; j < 3; j++) begin
      rreq_in = rnd_slot(8'h05);
      #1;
      checks++; if (lreq_in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_full_ready[%0d]: got %b want 0", j, lreq_in_ready); end
      checks++; if (!(rreq_out_valid === 1'b1 && rreq_out_address[31:24] === 8'h05))
        begin errors++; $display("FAIL bp_no_inject[%0d]: got v=%b addr=%h", j, rreq_out_valid, rreq_out_address); end
      tick();
    end
    rreq_in = '0;
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      got = exp_q.pop_front();
      checks++; if (ring_req_out() !== got)
        begin errors++; $display("FAIL bp_drain[%0d]: got %h want %h", k, ring_req_out(), got); end
      if (k == 0) begin
        checks++; if (lreq_in_ready !== 1'b1)
          begin errors++; $display("FAIL bp_ready_back: got %b want 1", lreq_in_ready); end
      end
    end
    tick();
    checks++; if (rreq_out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_empty: got %b want 0", rreq_out_valid); end
  endtask

  task automatic test_response();
    t_slot ring_rsp, loc_rsp, other;
    core_id = 8'h28;
    do_reset();
    ring_rsp = rnd_slot(8'h11);
    ring_rsp.requestor = 10'h0A1;
    loc_rsp = rnd_slot(8'h33);
    rrsp_in = ring_rsp;
    lrsp_in = loc_rsp;
    #1;
    checks++; if (lrsp_in_ready !== 1'b1)
      begin errors++; $display("FAIL rsp_ready_empty: got %b want 1", lrsp_in_ready); end
    tick();
    rrsp_in = '0; lrsp_in = '0;
    #1;
    checks++; if (loc_rsp_out() !== ring_rsp)
      begin errors++; $display("FAIL rsp_eject: got %h want %h", loc_rsp_out(), ring_rsp); end
    tick();
    checks++; if (ring_rsp_out() !== loc_rsp)
      begin errors++; $display("FAIL rsp_inject: got %h want %h", ring_rsp_out(), loc_rsp); end
    checks++; if (lrsp_out_valid !== 1'b0)
      begin errors++; $display("FAIL rsp_pulse_width: got %b want 0", lrsp_out_valid); end
    // Holder occupied while the passing response is not ours: ready must drop.
    other = rnd_slot(8'h44);
    other.requestor = 10'h3FF;
    loc_rsp = rnd_slot(8'h55);
    rrsp_in = other;
    lrsp_in = loc_rsp;
    tick();
    rrsp_in = '0; lrsp_in = '0;
    #1;
    checks++; if (lrsp_in_ready !== 1'b0)
      begin errors++; $display("FAIL rsp_ready_blocked: got %b want 0", lrsp_in_ready); end
    tick();
    checks++; if (ring_rsp_out() !== other)
      begin errors++; $display("FAIL rsp_forward: got %h want %h", ring_rsp_out(), other); end
    checks++; if (lrsp_in_ready !== 1'b1)
      begin errors++; $display("FAIL rsp_ready_injecting: got %b want 1", lrsp_in_ready); end
    tick();
    checks++; if (ring_rsp_out() !== loc_rsp)
      begin errors++; $display("FAIL rsp_inject2: got %h want %h", ring_rsp_out(), loc_rsp); end
  endtask

  task automatic test_reset_mid();
    core_id = 8'h02;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rreq_in = rnd_slot(8'h05);
      rrsp_in = rnd_slot(8'h05);
      rrsp_in.requestor = 10'h3FF;
      lreq_in = rnd_slot(8'h07);
      lrsp_in = rnd_slot(8'h07);
      tick();
    end
    lreq_in = '0; lrsp_in = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({ring_req_out(), ring_rsp_out(), loc_req_out(), loc_rsp_out(), lreq_in_ready, lrsp_in_ready} !== '0)
      begin errors++; $display("FAIL midreset_outputs: got req=%h rsp=%h rdy=%b want all 0", ring_req_out(), ring_rsp_out(), {lreq_in_ready, lrsp_in_ready}); end
    drive_idle();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({rreq_out_valid, rrsp_out_valid} !== 2'b00)
        begin errors++; $display("FAIL midreset_leftover[%0d]: got %b want 00", i, {rreq_out_valid, rrsp_out_valid}); end
    end
    for (int i = 0; i < 5; i++) begin
      rreq_in = rnd_slot(8'h05);
      lreq_in = rnd_slot(8'h07);
      #1;
      checks++; if (lreq_in_ready !== (i < DEPTH))
        begin errors++; $display("FAIL midreset_count[%0d]: got %b want %b", i, lreq_in_ready, (i < DEPTH)); end
      tick();
    end
    drive_idle();
    repeat (DEPTH + 2) tick();
  endtask

  // Randomized traffic against a slot-level model of the ring stop rules.
  task automatic test_random();
    t_slot m_req501, m_rsp501, m_hold, exp_req, exp_rsp;
    t_slot m_fifo[$];
    logic  exp_lreq_v, exp_lrsp_v, exp_req_rdy, exp_rsp_rdy, ejected;
    int    m_fwd, m_inj, m_ej, m_bnc;
    core_id = 8'($urandom_range(0, 255));
    do_reset();
    m_req501 = '0; m_rsp501 = '0; m_hold = '0; exp_req = '0; exp_rsp = '0;
    m_fwd = 0; m_inj = 0; m_ej = 0; m_bnc = 0;
    for (int n = 0; n < 300; n++) begin
      rreq_in = rnd_slot(($urandom_range(0, 2) == 0) ? core_id : 8'($urandom_range(0, 255)));
      rreq_in.valid = ($urandom_range(0, 3) != 0);
      rrsp_in = rnd_slot(8'h00);
      rrsp_in.requestor = {(($urandom_range(0, 2) == 0) ? core_id : 8'($urandom_range(0, 255))), 2'($urandom_range(0, 3))};
      rrsp_in.valid = ($urandom_range(0, 3) != 0);
      lreq_in = rnd_slot(8'($urandom_range(0, 255)));
      lreq_in.valid = $urandom_range(0, 1);
      lrsp_in = rnd_slot(8'($urandom_range(0, 255)));
      lrsp_in.valid = $urandom_range(0, 1);
      lreq_out_ready = $urandom_range(0, 1);
      #1;
      exp_lreq_v  = m_req501.valid && (m_req501.address[31:24] == core_id);
      exp_lrsp_v  = m_rsp501.valid && (m_rsp501.requestor[9:2] == core_id);
      exp_req_rdy = (m_fifo.size() < DEPTH);
      exp_rsp_rdy = !m_hold.valid || !m_rsp501.valid || exp_lrsp_v;
      checks++; if (lreq_out_valid !== exp_lreq_v || (exp_lreq_v && loc_req_out() !== m_req501))
        begin errors++; $display("FAIL rnd_lreq_out[%0d]: got %h want v=%b %h", n, loc_req_out(), exp_lreq_v, m_req501); end
      checks++; if (lrsp_out_valid !== exp_lrsp_v || (exp_lrsp_v && loc_rsp_out() !== m_rsp501))
        begin errors++; $display("FAIL rnd_lrsp_out[%0d]: got %h want v=%b %h", n, loc_rsp_out(), exp_lrsp_v, m_rsp501); end
      checks++; if ({lreq_in_ready, lrsp_in_ready} !== {exp_req_rdy, exp_rsp_rdy})
        begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, {lreq_in_ready, lrsp_in_ready}, {exp_req_rdy, exp_rsp_rdy}); end
      // Request ring: resident slot wins, otherwise oldest local request.
      ejected = exp_lreq_v && lreq_out_ready;
      if (ejected) m_ej++;
      if (exp_lreq_v && !lreq_out_ready) m_bnc++;
      if (m_req501.valid && !ejected) begin
        exp_req = m_req501; m_fwd++;
      end else if (m_fifo.size() > 0) begin
        exp_req = m_fifo.pop_front(); m_inj++;
      end else begin
        exp_req.valid = 1'b0;
      end
      // Response ring: resident non-local response wins over the holder.
      if (m_rsp501.valid && !exp_lrsp_v) begin
        exp_rsp = m_rsp501;
      end else if (m_hold.valid) begin
        exp_rsp = m_hold; m_hold.valid = 1'b0;
      end else begin
        exp_rsp.valid = 1'b0;
      end
      if (lreq_in.valid && exp_req_rdy) m_fifo.push_back(lreq_in);
      if (lrsp_in.valid && exp_rsp_rdy) m_hold = lrsp_in;
      m_req501 = rreq_in;
      m_rsp501 = rrsp_in;
      tick();
      checks++; if (rreq_out_valid !== exp_req.valid || (exp_req.valid && ring_req_out() !== exp_req))
        begin errors++; $display("FAIL rnd_ring_req[%0d]: got %h want %h", n, ring_req_out(), exp_req); end
      checks++; if (rrsp_out_valid !== exp_rsp.valid || (exp_rsp.valid && ring_rsp_out() !== exp_rsp))
        begin errors++; $display("FAIL rnd_ring_rsp[%0d]: got %h want %h", n, ring_rsp_out(), exp_rsp); end
    end
`ifdef RING_STOP_PERF_CNT_EN
    checks++; if ({perf_fwd, perf_inj, perf_ej, perf_bounce} !== {16'(m_fwd), 16'(m_inj), 16'(m_ej), 16'(m_bnc)})
      begin errors++; $display("FAIL rnd_perf: got %0d %0d %0d %0d want %0d %0d %0d %0d", perf_fwd, perf_inj, perf_ej, perf_bounce, m_fwd, m_inj, m_ej, m_bnc); end
`endif
    drive_idle();
    repeat (3) tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_forward();
    test_eject();
    test_bounce();
    test_backpressure();
    test_response();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
